// File: rtl/body_regfile_avl.sv
// Avalon-MM register file for rigid-body records plus the force-resolve engine
// START/BUSY/DONE handshake and frame-synchronous render snapshots.
module body_regfile_avl #(
  parameter int N_BODIES = 10,
  parameter int FIELDS   = 10,
  parameter int ADDR_W   = 8,
  parameter int SNAP_W   = 10
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       AVL_CS,
  input  logic                       AVL_READ,
  input  logic                       AVL_WRITE,
  input  logic [3:0]                 AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]          AVL_ADDR,
  input  logic [31:0]                AVL_WRITEDATA,
  output logic [31:0]                AVL_READDATA,
  output logic                       AVL_READDATAVALID,
  output logic                       ENG_START,
  input  logic                       ENG_DONE,
  input  logic [2:0]                 ENG_WE,
  input  logic [3*ADDR_W-1:0]        ENG_ADDR,
  input  logic [95:0]                ENG_DATA,
  input  logic [ADDR_W-1:0]          ENG_RD_ADDR,
  output logic [31:0]                ENG_RD_DATA,
  input  logic                       FRAME_SYNC,
  output logic [N_BODIES*SNAP_W-1:0] SNAP_RAD,
  output logic [N_BODIES*SNAP_W-1:0] SNAP_X,
  output logic [N_BODIES*SNAP_W-1:0] SNAP_Y,
  output logic [N_BODIES*SNAP_W-1:0] SNAP_Z,
  output logic                       SNAP_VALID
);

  localparam int NB = FIELDS * N_BODIES;

  // state  | meaning
  // S_IDLE | engine stopped; CTRL START write launches it; snapshots copy directly
  // S_RUN  | engine running; ENG_START held, CTRL writes ignored, frame edges deferred
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]                r_num;
  logic [31:0]                r_body     [NB];
  logic [31:0]                w_body_nxt [NB];
  logic                       r_done;
  logic                       r_fs_q;
  logic                       r_pending;
  logic [31:0]                r_rdata;
  logic                       r_rvalid;
  logic                       r_snap_valid;
  logic [N_BODIES*SNAP_W-1:0] r_snap_rad;
  logic [N_BODIES*SNAP_W-1:0] r_snap_x;
  logic [N_BODIES*SNAP_W-1:0] r_snap_y;
  logic [N_BODIES*SNAP_W-1:0] r_snap_z;

  logic        w_host_wr;
  logic        w_host_rd;
  logic        w_ctrl_start;
  logic        w_status_w1c;
  logic        w_busy;
  logic        w_eng_start;
  logic        w_fs_rise;
  logic        w_snap_copy;
  logic [31:0] w_avl_word;
  logic [31:0] w_eng_word;

  assign w_host_wr    = AVL_CS & AVL_WRITE;
  assign w_host_rd    = AVL_CS & AVL_READ;
  assign w_ctrl_start = w_host_wr && (AVL_ADDR == ADDR_W'(1)) && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  assign w_status_w1c = w_host_wr && (AVL_ADDR == ADDR_W'(2)) && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  assign w_fs_rise    = FRAME_SYNC & ~r_fs_q;
  // a deferred edge is serviced in the first IDLE cycle after the engine finishes
  assign w_snap_copy  = ~w_busy & (w_fs_rise | r_pending);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ctrl_start) w_state_nxt = S_RUN;
      S_RUN:   if (ENG_DONE)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state == S_RUN);
    w_eng_start = w_busy;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                               r_done <= 1'b0;
    else if (w_busy && ENG_DONE)             r_done <= 1'b1;
    else if (!w_busy && w_ctrl_start)        r_done <= 1'b0;
    else if (w_status_w1c)                   r_done <= 1'b0;
  end

  // engine ports apply in index order so the highest port wins; host bytes land on top
  always_comb begin
    for (int k = 0; k < NB; k++) begin
      w_body_nxt[k] = r_body[k];
      for (int p = 0; p < 3; p++) begin
        if (ENG_WE[p] && (ENG_ADDR[p*ADDR_W +: ADDR_W] == ADDR_W'(3 + k)))
          w_body_nxt[k] = ENG_DATA[p*32 +: 32];
      end
      for (int b = 0; b < 4; b++) begin
        if (w_host_wr && (AVL_ADDR == ADDR_W'(3 + k)) && AVL_BYTE_EN[b])
          w_body_nxt[k][b*8 +: 8] = AVL_WRITEDATA[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < NB; k++) r_body[k] <= '0;
    end else begin
      for (int k = 0; k < NB; k++) r_body[k] <= w_body_nxt[k];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_num <= '0;
    end else if (w_host_wr && (AVL_ADDR == ADDR_W'(0))) begin
      for (int b = 0; b < 4; b++)
        if (AVL_BYTE_EN[b]) r_num[b*8 +: 8] <= AVL_WRITEDATA[b*8 +: 8];
    end
  end

  always_comb begin
    w_avl_word = '0;
    if (AVL_ADDR == ADDR_W'(0))      w_avl_word = r_num;
    else if (AVL_ADDR == ADDR_W'(1)) w_avl_word = {31'd0, w_busy};
    else if (AVL_ADDR == ADDR_W'(2)) w_avl_word = {30'd0, w_busy, r_done};
    for (int k = 0; k < NB; k++)
      if (AVL_ADDR == ADDR_W'(3 + k)) w_avl_word = r_body[k];
  end

  always_comb begin
    w_eng_word = '0;
    if (ENG_RD_ADDR == ADDR_W'(0))      w_eng_word = r_num;
    else if (ENG_RD_ADDR == ADDR_W'(1)) w_eng_word = {31'd0, w_busy};
    else if (ENG_RD_ADDR == ADDR_W'(2)) w_eng_word = {30'd0, w_busy, r_done};
    for (int k = 0; k < NB; k++)
      if (ENG_RD_ADDR == ADDR_W'(3 + k)) w_eng_word = r_body[k];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_host_rd;
      if (w_host_rd) r_rdata <= w_avl_word;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_fs_q    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_fs_q <= FRAME_SYNC;
      if (w_snap_copy)             r_pending <= 1'b0;
      else if (w_busy && w_fs_rise) r_pending <= 1'b1;
    end
  end

  // field order: 1 = rad, 2 = px, 3 = py, 4 = pz
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_snap_valid <= 1'b0;
      r_snap_rad   <= '0;
      r_snap_x     <= '0;
      r_snap_y     <= '0;
      r_snap_z     <= '0;
    end else begin
      r_snap_valid <= w_snap_copy;
      if (w_snap_copy) begin
        for (int i = 0; i < N_BODIES; i++) begin
          r_snap_rad[i*SNAP_W +: SNAP_W] <= r_body[1*N_BODIES + i][SNAP_W-1:0];
          r_snap_x[i*SNAP_W +: SNAP_W]   <= r_body[2*N_BODIES + i][SNAP_W-1:0];
          r_snap_y[i*SNAP_W +: SNAP_W]   <= r_body[3*N_BODIES + i][SNAP_W-1:0];
          r_snap_z[i*SNAP_W +: SNAP_W]   <= r_body[4*N_BODIES + i][SNAP_W-1:0];
        end
      end
    end
  end

  assign AVL_READDATA      = r_rdata;
  assign AVL_READDATAVALID = r_rvalid;
  assign ENG_START         = w_eng_start;
  assign ENG_RD_DATA       = w_eng_word;
  assign SNAP_RAD          = r_snap_rad;
  assign SNAP_X            = r_snap_x;
  assign SNAP_Y            = r_snap_y;
  assign SNAP_Z            = r_snap_z;
  assign SNAP_VALID        = r_snap_valid;

endmodule
